ram_param_fill: RTL and testbench

- Parametrised single-port register-file RAM; successor to the fixed 8x8 flip-flop RAM.
- Generic WIDTH/DEPTH, registered read with a valid strobe, async clear of all contents.
- Hardware fill engine that writes a constant to every word, one word per cycle, with a busy flag.
- Used as general scratch storage in the datapath test benches.

---
 rtl/ram_param_fill.sv | 126 ++++++++++++
 tb/tb_ram_param_fill.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_param_fill.sv
// rtl/ram_param_fill.sv - parametrised register-file RAM with registered read and a hardware fill sweep
module ram_param_fill #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req,
  input  logic              r_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  in,
  input  logic              fill,
  input  logic [WIDTH-1:0]  fill_data,
  output logic [WIDTH-1:0]  out,
  output logic              valid,
  output logic              busy
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    fill_val_q, fill_val_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    rdata;
  logic                in_range;

  assign in_range = ({1'b0, addr} < DEPTH_W);

  // Out-of-range addresses fall through to zero, which is what a read of them returns.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) rdata = mem_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    mem_waddr  = addr;
    mem_wdata  = in;
    case (state_q)
      IDLE: begin
        if (fill) begin
          fill_val_d = fill_data;
          cnt_d      = '0;
          state_d    = FILL;
          busy_d     = 1'b1;
        end else if (req) begin
          if (r_w) begin
            mem_we = in_range;
          end else begin
            out_d   = in_range ? rdata : '0;
            valid_d = 1'b1;
          end
        end
      end
      FILL: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = fill_val_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fill_val_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_val_q <= fill_val_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_we && mem_waddr == ADDR_W'(i)) mem_q[i] <= mem_wdata;
      end
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ram_param_fill.sv
// tb/tb_ram_param_fill.sv - directed bench for ram_param_fill (default 8x8 and a 6x16 instance)
module tb_ram_param_fill;

  logic        clk = 1'b0;
  logic        clear;
  logic        req, r_w, fill;
  logic [2:0]  addr;
  logic [7:0]  din, fill_data, dout;
  logic        valid, busy;
  logic        req6, r_w6, fill6;
  logic [2:0]  addr6;
  logic [15:0] din6, fill_data6, dout6;
  logic        valid6, busy6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_param_fill u8 (
    .clk(clk), .clear(clear), .req(req), .r_w(r_w), .addr(addr), .in(din),
    .fill(fill), .fill_data(fill_data), .out(dout), .valid(valid), .busy(busy)
  );

  ram_param_fill #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) u6 (
    .clk(clk), .clear(clear), .req(req6), .r_w(r_w6), .addr(addr6), .in(din6),
    .fill(fill6), .fill_data(fill_data6), .out(dout6), .valid(valid6), .busy(busy6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr8(input logic [2:0] a, input logic [7:0] d);
    req = 1'b1; r_w = 1'b1; addr = a; din = d;
    tick();
    req = 1'b0;
  endtask

  task automatic rd8(input string tag, input logic [2:0] a, input logic [7:0] exp);
    req = 1'b1; r_w = 1'b0; addr = a;
    tick();
    check({tag, "_out"}, {24'd0, dout}, {24'd0, exp});
    check({tag, "_valid"}, {31'd0, valid}, 32'd1);
    req = 1'b0;
  endtask

  task automatic wr6(input logic [2:0] a, input logic [15:0] d);
    req6 = 1'b1; r_w6 = 1'b1; addr6 = a; din6 = d;
    tick();
    req6 = 1'b0;
  endtask

  task automatic rd6(input string tag, input logic [2:0] a, input logic [15:0] exp);
    req6 = 1'b1; r_w6 = 1'b0; addr6 = a;
    tick();
    check({tag, "_out"}, {16'd0, dout6}, {16'd0, exp});
    check({tag, "_valid"}, {31'd0, valid6}, 32'd1);
    req6 = 1'b0;
  endtask

  // Counts cycles with busy high, starting right after the edge that accepted fill.
  task automatic count_busy8(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic count_busy6(output int n);
    n = 0;
    while (busy6 && n < 50) begin
      n++;
      tick();
    end
  endtask

  logic [7:0] pat [8];
  int n;

  initial begin
    pat[0] = 8'd1;  pat[1] = 8'd3;  pat[2] = 8'd7;   pat[3] = 8'd15;
    pat[4] = 8'd31; pat[5] = 8'd63; pat[6] = 8'd127; pat[7] = 8'd255;
    clear = 1'b1; req = 0; r_w = 0; fill = 0; addr = 0; din = 0; fill_data = 0;
    req6 = 0; r_w6 = 0; fill6 = 0; addr6 = 0; din6 = 0; fill_data6 = 0;

    // Reset
    tick(); tick();
    check("rst_out", {24'd0, dout}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    clear = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) rd8("rst_rd", 3'(i), 8'h00);

    // Write then back-to-back read
    for (int i = 0; i < 8; i++) begin
      wr8(3'(i), pat[i]);
      check("wr_valid", {31'd0, valid}, 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; r_w = 1'b0; addr = 3'(i);
      tick();
      check("b2b_out", {24'd0, dout}, {24'd0, pat[i]});
      check("b2b_valid", {31'd0, valid}, 32'd1);
    end
    req = 1'b0;
    tick();
    check("idle_valid", {31'd0, valid}, 32'd0);
    check("idle_out_hold", {24'd0, dout}, 32'd255);

    // Read immediately after write to same address
    wr8(3'd5, 8'h42);
    rd8("raw", 3'd5, 8'h42);

    // Fill sweep
    fill = 1'b1; fill_data = 8'hA5;
    tick();
    fill = 1'b0; fill_data = 8'h00;
    count_busy8(n);
    check("fill_busy_cycles", n, 32'd8);
    for (int i = 0; i < 8; i++) rd8("fill_rd", 3'(i), 8'hA5);

    // Interlock: reqs during busy, fill_data changed mid-sweep
    fill = 1'b1; fill_data = 8'h5A;
    tick();
    fill = 1'b0;
    req = 1'b1; r_w = 1'b1; addr = 3'd2; din = 8'h3C; fill_data = 8'h11;
    tick();
    check("lock_busy", {31'd0, busy}, 32'd1);
    check("lock_wr_valid", {31'd0, valid}, 32'd0);
    r_w = 1'b0; fill = 1'b1;
    tick();
    check("lock_rd_valid", {31'd0, valid}, 32'd0);
    check("lock_out_hold", {24'd0, dout}, 32'hA5);
    req = 1'b0; fill = 1'b0;
    count_busy8(n);
    check("lock_busy_left", n, 32'd6);
    for (int i = 0; i < 8; i++) rd8("lock_rd", 3'(i), 8'h5A);

    // fill and req in the same cycle: req dropped
    fill = 1'b1; fill_data = 8'hC3; req = 1'b1; r_w = 1'b0; addr = 3'd0;
    tick();
    check("fill_rd_drop_valid", {31'd0, valid}, 32'd0);
    fill = 1'b0; req = 1'b0;
    count_busy8(n);
    check("fill_rd_busy", n, 32'd8);
    fill = 1'b1; fill_data = 8'h96; req = 1'b1; r_w = 1'b1; addr = 3'd4; din = 8'h77;
    tick();
    fill = 1'b0; req = 1'b0;
    count_busy8(n);
    rd8("fill_wr_drop", 3'd4, 8'h96);
    rd8("fill_wr_other", 3'd1, 8'h96);

    // Clear mid-fill
    fill = 1'b1; fill_data = 8'hFF;
    tick();
    fill = 1'b0;
    tick(); tick(); tick();
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2 clear = 1'b1;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_out", {24'd0, dout}, 32'd0);
    #1 clear = 1'b0;
    tick();
    check("mid_busy_after", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) rd8("mid_rd", 3'(i), 8'h00);

    // 6x16 instance: out-of-range handling and fill length
    for (int i = 0; i < 6; i++) wr6(3'(i), 16'h1000 + 16'(i));
    wr6(3'd7, 16'hBEEF);
    wr6(3'd6, 16'hBEEF);
    for (int i = 0; i < 6; i++) rd6("oor_keep", 3'(i), 16'h1000 + 16'(i));
    rd6("oor_rd7", 3'd7, 16'h0000);
    rd6("oor_rd5", 3'd5, 16'h1005);
    rd6("oor_rd6", 3'd6, 16'h0000);
    fill6 = 1'b1; fill_data6 = 16'hC0DE;
    tick();
    fill6 = 1'b0;
    count_busy6(n);
    check("d6_fill_busy", n, 32'd6);
    rd6("d6_fill0", 3'd0, 16'hC0DE);
    rd6("d6_fill5", 3'd5, 16'hC0DE);
    rd6("d6_fill7", 3'd7, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
